int_to_fp_pipe: RTL and testbench

//  Parametrised pipelined integer-to-floating-point converter: next-generation int->fp front end of the fp arithmetic library.
//  Per-transaction signed/unsigned mode, round-to-nearest-even or truncate, valid/ready backpressure, inexact/overflow flags.
//  Any InWidth >= 2 (power of two not required); any ExpWidth/ManWidth pair. Zero and most-negative input handled exactly.

---
 rtl/int_to_fp_pipe.sv | 135 +++++++++++++
 tb/tb_int_to_fp_pipe.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_to_fp_pipe.sv
// Pipelined integer-to-floating-point converter: magnitude, normalise, round/pack.
// Valid/ready handshake with a single global advance; per-transaction signed and rounding mode.
module int_to_fp_pipe #(
  parameter int unsigned InWidth  = 32,
  parameter int unsigned ExpWidth = 8,
  parameter int unsigned ManWidth = 23,
  parameter int unsigned ExpBias  = 127
) (
  input  logic                         Clk_i,
  input  logic                         RstN_i,
  input  logic [InWidth-1:0]           InData_i,
  input  logic                         InSigned_i,
  input  logic                         InRndMode_i,
  input  logic                         InVal_i,
  output logic                         InReady_o,
  output logic [ExpWidth+ManWidth:0]   OutData_o,
  output logic                         OutInexact_o,
  output logic                         OutOverflow_o,
  output logic                         OutVal_o,
  input  logic                         OutReady_i
);

  localparam int unsigned PosW  = $clog2(InWidth);
  localparam int unsigned LowW  = InWidth + ManWidth + 1;
  localparam int unsigned ExpNeed = $clog2(ExpBias + InWidth + 1) + 1;
  // Exponent is carried wide enough that bias + position + carry can never wrap.
  localparam int unsigned ExpW  = (ExpWidth + 2 > ExpNeed) ? ExpWidth + 2 : ExpNeed;

  logic advance;
  assign advance   = ~OutVal_o | OutReady_i;
  assign InReady_o = advance;

  // Stage 1: sign and absolute magnitude (most-negative value maps to 2^(InWidth-1))
  logic               inNeg;
  logic [InWidth-1:0] inMag;
  logic               s1Val, s1Sign, s1Rnd;
  logic [InWidth-1:0] s1Mag;

  assign inNeg = InSigned_i & InData_i[InWidth-1];
  assign inMag = inNeg ? (~InData_i + InWidth'(1)) : InData_i;

  always_ff @(posedge Clk_i or negedge RstN_i) begin
    if (!RstN_i) begin
      s1Val  <= 1'b0;
      s1Sign <= 1'b0;
      s1Rnd  <= 1'b0;
      s1Mag  <= '0;
    end else if (advance) begin
      s1Val  <= InVal_i;
      s1Sign <= inNeg;
      s1Rnd  <= InRndMode_i;
      s1Mag  <= inMag;
    end
  end

  // Stage 2: locate MSB, left-normalise, split into mantissa / guard / sticky
  logic [PosW-1:0]    msbPos;
  logic [InWidth-1:0] normMag;
  logic [LowW-1:0]    normExt;

  always_comb begin
    msbPos = '0;
    for (int i = 0; i < InWidth; i++) begin
      if (s1Mag[i]) msbPos = PosW'(i);
    end
  end

  assign normMag = s1Mag << (PosW'(InWidth - 1) - msbPos);
  assign normExt = {normMag[InWidth-2:0], {(ManWidth + 2){1'b0}}};

  logic                s2Val, s2Sign, s2Zero, s2Rnd, s2Guard, s2Sticky;
  logic [ExpW-1:0]     s2Exp;
  logic [ManWidth-1:0] s2Man;

  always_ff @(posedge Clk_i or negedge RstN_i) begin
    if (!RstN_i) begin
      s2Val    <= 1'b0;
      s2Sign   <= 1'b0;
      s2Zero   <= 1'b0;
      s2Rnd    <= 1'b0;
      s2Guard  <= 1'b0;
      s2Sticky <= 1'b0;
      s2Exp    <= '0;
      s2Man    <= '0;
    end else if (advance) begin
      s2Val    <= s1Val;
      s2Sign   <= s1Sign;
      s2Zero   <= ~normMag[InWidth-1];
      s2Rnd    <= s1Rnd;
      s2Guard  <= normExt[InWidth];
      s2Sticky <= |normExt[InWidth-1:0];
      s2Exp    <= ExpW'(ExpBias) + ExpW'(msbPos);
      s2Man    <= normExt[LowW-1 -: ManWidth];
    end
  end

  // Stage 3: round, detect overflow after any mantissa carry, pack
  logic                roundUp, manCarry, ovf, inexact;
  logic [ManWidth-1:0] manRnd, resMan;
  logic [ExpW-1:0]     expRnd;
  logic [ExpWidth-1:0] resExp;

  assign roundUp            = ~s2Rnd & s2Guard & (s2Sticky | s2Man[0]);
  assign {manCarry, manRnd} = {1'b0, s2Man} + (ManWidth + 1)'(roundUp);
  assign expRnd             = s2Exp + ExpW'(manCarry);
  assign ovf                = ~s2Zero & (expRnd >= {{(ExpW - ExpWidth){1'b0}}, {ExpWidth{1'b1}}});
  assign inexact            = ~s2Zero & (s2Guard | s2Sticky | ovf);

  always_comb begin
    resExp = expRnd[ExpWidth-1:0];
    resMan = manRnd;
    if (s2Zero) begin
      resExp = '0;
      resMan = '0;
    end else if (ovf) begin
      resExp = s2Rnd ? {{(ExpWidth - 1){1'b1}}, 1'b0} : {ExpWidth{1'b1}};
      resMan = s2Rnd ? {ManWidth{1'b1}} : {ManWidth{1'b0}};
    end
  end

  always_ff @(posedge Clk_i or negedge RstN_i) begin
    if (!RstN_i) begin
      OutVal_o      <= 1'b0;
      OutData_o     <= '0;
      OutInexact_o  <= 1'b0;
      OutOverflow_o <= 1'b0;
    end else if (advance) begin
      OutVal_o      <= s2Val;
      OutData_o     <= {s2Sign & ~s2Zero, resExp, resMan};
      OutInexact_o  <= inexact;
      OutOverflow_o <= ovf;
    end
  end

endmodule

// File: tb/tb_int_to_fp_pipe.sv
// Self-checking bench for int_to_fp_pipe: single-precision instance plus a 17-bit-in half-precision instance.
module tb_int_to_fp_pipe;

  logic        clk, rstN;
  logic [31:0] inData;
  logic        inSigned, inRnd, inVal, inReady;
  logic [31:0] outData;
  logic        outInex, outOvf, outVal, outReady;

  logic [16:0] hData;
  logic        hSigned, hRnd, hVal, hReady;
  logic [15:0] hOutData;
  logic        hInex, hOvf, hOutVal, hOutReady;

  int checks   = 0;
  int failures = 0;

  int_to_fp_pipe dut (
    .Clk_i(clk), .RstN_i(rstN), .InData_i(inData), .InSigned_i(inSigned),
    .InRndMode_i(inRnd), .InVal_i(inVal), .InReady_o(inReady), .OutData_o(outData),
    .OutInexact_o(outInex), .OutOverflow_o(outOvf), .OutVal_o(outVal), .OutReady_i(outReady)
  );

  int_to_fp_pipe #(.InWidth(17), .ExpWidth(5), .ManWidth(10), .ExpBias(15)) dutH (
    .Clk_i(clk), .RstN_i(rstN), .InData_i(hData), .InSigned_i(hSigned),
    .InRndMode_i(hRnd), .InVal_i(hVal), .InReady_o(hReady), .OutData_o(hOutData),
    .OutInexact_o(hInex), .OutOverflow_o(hOvf), .OutVal_o(hOutVal), .OutReady_i(hOutReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact integer value divided down by a power of two, rounded via remainder comparison.
  // Returns {overflow, inexact, packed result (low bits)}.
  function automatic logic [33:0] ref_fp(input longint unsigned d, input bit sg, input bit tr,
                                         input int inw, input int ew, input int mw, input int bias);
    longint unsigned one = 1;
    longint unsigned m, q, rem, half, man, e, res;
    int p, sh;
    bit neg, inex, ovf;
    neg = sg && (((d >> (inw - 1)) & one) != 0);
    m = neg ? (one << inw) - d : d;
    if (m == 0) return '0;
    p = 0;
    while ((m >> (p + 1)) != 0) p++;
    inex = 0;
    ovf  = 0;
    if (p <= mw) q = m << (mw - p);
    else begin
      sh   = p - mw;
      q    = m >> sh;
      rem  = m - (q << sh);
      half = one << (sh - 1);
      inex = (rem != 0);
      if (!tr && (rem > half || (rem == half && q[0]))) q++;
      if (q == (one << (mw + 1))) begin
        q = q >> 1;
        p++;
      end
    end
    e = longint'(bias + p);
    if (e >= (one << ew) - 1) begin
      ovf  = 1;
      inex = 1;
      e    = tr ? (one << ew) - 2 : (one << ew) - 1;
      man  = tr ? (one << mw) - 1 : 0;
    end else man = q - (one << mw);
    res = (neg ? (one << (ew + mw)) : 0) | (e << mw) | man;
    return {ovf, inex, res[31:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstN = 1'b0; inData = '0; inSigned = 0; inRnd = 0; inVal = 0; outReady = 1;
    hData = '0; hSigned = 0; hRnd = 0; hVal = 0; hOutReady = 1;
    #12;
    checks++;
    if ({outVal, outInex, outOvf, outData} !== 35'd0) begin
      failures++;
      $display("FAIL reset_outputs: got val=%b inex=%b ovf=%b data=%h want all zero", outVal, outInex, outOvf, outData);
    end
    checks++;
    if ({hOutVal, hInex, hOvf, hOutData} !== 19'd0) begin
      failures++;
      $display("FAIL reset_half_outputs: got val=%b data=%h want all zero", hOutVal, hOutData);
    end
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    checks++;
    if (inReady !== 1'b1 || hReady !== 1'b1) begin
      failures++;
      $display("FAIL reset_inready: got %b/%b want 1/1", inReady, hReady);
    end
  endtask

  task automatic test_directed();
    logic [31:0] vd[8]  = '{32'h1, 32'hFFFFFFFF, 32'h0, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h01000001, 32'h01000003};
    bit          vs[8]  = '{1, 1, 1, 1, 0, 0, 0, 0};
    bit          vr[8]  = '{0, 0, 0, 0, 0, 1, 0, 0};
    logic [33:0] vx[8]  = '{{2'b00, 32'h3F800000}, {2'b00, 32'hBF800000}, {2'b00, 32'h00000000},
                            {2'b00, 32'hCF000000}, {2'b01, 32'h4F800000}, {2'b01, 32'h4F7FFFFF},
                            {2'b01, 32'h4B800000}, {2'b01, 32'h4B800002}};
    outReady = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      inVal = 1; inData = vd[i]; inSigned = vs[i]; inRnd = vr[i];
      @(posedge clk); #1;
      inVal = 0;
      @(posedge clk); #1;
      checks++;
      if (outVal !== 1'b0) begin
        failures++;
        $display("FAIL directed_early[%0d]: OutVal_o=%b want 0 two cycles after acceptance", i, outVal);
      end
      @(posedge clk); #1;
      checks++;
      if (outVal !== 1'b1 || {outOvf, outInex, outData} !== vx[i]) begin
        failures++;
        $display("FAIL directed[%0d] in=%h: got val=%b %b%b %h want val=1 %b %h", i, vd[i], outVal, outOvf, outInex, outData, vx[i][33:32], vx[i][31:0]);
      end
    end
  endtask

  task automatic test_half();
    logic [16:0] vd[3] = '{17'd65504, 17'd65520, 17'd65536};
    bit          vr[3] = '{0, 0, 1};
    logic [17:0] vx[3] = '{{2'b00, 16'h7BFF}, {2'b11, 16'h7C00}, {2'b11, 16'h7BFF}};
    logic [33:0] m;
    logic [17:0] want;
    for (int i = 0; i < 23; i++) begin
      tick();
      hVal = 1;
      if (i < 3) begin hData = vd[i]; hSigned = 0; hRnd = vr[i]; end
      else begin hData = 17'($urandom); hSigned = 1'($urandom); hRnd = 1'($urandom); end
      m    = ref_fp(64'(hData), hSigned, hRnd, 17, 5, 10, 15);
      want = (i < 3) ? vx[i] : {m[33:32], m[15:0]};
      @(posedge clk); #1;
      hVal = 0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++;
      if (hOutVal !== 1'b1 || {hOvf, hInex, hOutData} !== want) begin
        failures++;
        $display("FAIL half[%0d] in=%h s=%b t=%b: got val=%b %b%b %h want %b %h", i, hData, hSigned, hRnd, hOutVal, hOvf, hInex, hOutData, want[17:16], want[15:0]);
      end
    end
  endtask

  // Streams nItems through the single-precision instance; scheduled (randomMode=0) or randomised stalls/bubbles.
  task automatic run_stream(input int nItems, input bit randomMode, input int budget);
    logic [33:0] expQ[$];
    logic [33:0] want;
    logic [31:0] heldData = '0;
    logic        heldInex = 0, heldOvf = 0, prevStall = 0;
    int sent = 0, got = 0, cyc = 0;
    logic [31:0] nd = $urandom;
    bit          ns = 1'($urandom), nr = 1'($urandom);
    while (got < nItems && cyc < budget) begin
      @(posedge clk); #1;
      inVal = (sent < nItems) && (!randomMode || $urandom_range(0, 9) < 7);
      inData = nd; inSigned = ns; inRnd = nr;
      if (randomMode) outReady = ($urandom_range(0, 3) != 0);
      else outReady = (cyc >= 4 && cyc <= 7) ? 1'b0 : ((cyc >= 8) ? cyc[0] : 1'b1);
      @(negedge clk);
      checks++;
      if (inReady !== !(outVal && !outReady)) begin
        failures++;
        $display("FAIL stream_inready cyc=%0d: got %b want %b", cyc, inReady, !(outVal && !outReady));
      end
      if (prevStall) begin
        checks++;
        if (outVal !== 1'b1 || outData !== heldData || outInex !== heldInex || outOvf !== heldOvf) begin
          failures++;
          $display("FAIL stream_hold cyc=%0d: got val=%b %h want held %h", cyc, outVal, outData, heldData);
        end
      end
      if (outVal && outReady) begin
        checks++;
        if (expQ.size() == 0) begin
          failures++;
          $display("FAIL stream_extra cyc=%0d: got unexpected output %h want none", cyc, outData);
        end else begin
          want = expQ.pop_front();
          got++;
          if ({outOvf, outInex, outData} !== want) begin
            failures++;
            $display("FAIL stream_data item=%0d: got %b%b %h want %b %h", got - 1, outOvf, outInex, outData, want[33:32], want[31:0]);
          end
        end
      end
      if (inVal && inReady) begin
        expQ.push_back(ref_fp(64'(inData), inSigned, inRnd, 32, 8, 23, 127));
        sent++;
        case ($urandom_range(0, 4))
          0: nd = $urandom;
          1: nd = $urandom >> $urandom_range(0, 31);
          2: nd = 32'h1 << $urandom_range(0, 31);
          3: nd = 32'h80000000;
          default: nd = 32'h01000000 | ($urandom & 32'h7);
        endcase
        ns = 1'($urandom);
        nr = 1'($urandom);
      end
      prevStall = outVal && !outReady;
      heldData  = outData;
      heldInex  = outInex;
      heldOvf   = outOvf;
      cyc++;
    end
    inVal = 0;
    outReady = 1;
    checks++;
    if (got != nItems) begin
      failures++;
      $display("FAIL stream_timeout: got %0d outputs want %0d within %0d cycles", got, nItems, budget);
    end
  endtask

  task automatic test_back_to_back();
    run_stream(8, 1'b0, 100);
  endtask

  task automatic test_random();
    run_stream(400, 1'b1, 4000);
  endtask

  task automatic test_reset_inflight();
    tick(); tick(); tick();
    outReady = 0;
    for (int i = 0; i < 3; i++) begin
      inVal = 1; inData = 32'h100 + 32'(i); inSigned = 0; inRnd = 0;
      tick();
    end
    inVal = 0;
    @(negedge clk);
    checks++;
    if (outVal !== 1'b1) begin
      failures++;
      $display("FAIL inflight_setup: OutVal_o=%b want 1 before reset", outVal);
    end
    #1 rstN = 1'b0;
    #1;
    checks++;
    if ({outVal, outInex, outOvf, outData} !== 35'd0) begin
      failures++;
      $display("FAIL inflight_async_reset: got val=%b data=%h want 0", outVal, outData);
    end
    @(negedge clk);
    rstN = 1'b1;
    outReady = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (outVal !== 1'b0) begin
        failures++;
        $display("FAIL inflight_ghost cyc=%0d: OutVal_o=%b data=%h want 0", i, outVal, outData);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_half();
    test_back_to_back();
    test_random();
    test_reset_inflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
